// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared boot ROM geometry and port id type for rom_arb2 and the ROM instance.
package config_pkg;

    localparam int ROM_ADDR_WIDTH = 8;
    localparam int ROM_DATA_WIDTH = 32;

    typedef logic rom_port_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way one-hot picker; ROM_ARB_ROUND_ROBIN_EN selects round-robin ties, else port 0 wins.
import config_pkg::*;

module rr_arb2 (
    input  logic [1:0] req_i,
    input  rom_port_t  last_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic [1:0] tie_gnt;
    // On a tie the port that did not win last time goes next.
    assign tie_gnt = last_i ? 2'b01 : 2'b10;
`else
    logic [1:0] tie_gnt;
    logic       unused_last;
    assign tie_gnt     = 2'b01;
    assign unused_last = last_i;
`endif

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = tie_gnt;
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/rom_arb2.sv
// rtl/rom_arb2.sv - two-port arbiter for the 1-cycle-latency boot ROM; tie policy set by ROM_ARB_ROUND_ROBIN_EN in rr_arb2.
import config_pkg::*;

module rom_arb2 #(
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid_i,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
    output logic [1:0]                 req_ready_o,
    output logic [1:0]                 rsp_valid_o,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    input  logic [1:0]                 rsp_ready_i,
    output logic                       rom_ce_o,
    output logic [ADDR_WIDTH-1:0]      rom_addr_o,
    input  logic [DATA_WIDTH-1:0]      rom_dout_i
);

    logic      pend_q, pend_d;
    rom_port_t owner_q, owner_d;
    rom_port_t last_q, last_d;

    logic       rsp_fire;
    logic       can_issue;
    logic [1:0] gnt;

    assign rsp_fire  = pend_q & rsp_ready_i[owner_q];
    assign can_issue = !pend_q | rsp_fire;

    // Grants are suppressed while reset is held so the ROM sees no read then.
    rr_arb2 u_arb (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .en_i   (can_issue & rst_n),
        .gnt_o  (gnt)
    );

    assign req_ready_o = gnt;
    assign rom_ce_o    = |gnt;
    assign rsp_data_o  = rom_dout_i;

    always_comb begin
        rom_addr_o = '0;
        if (gnt[0]) begin
            rom_addr_o = req_addr_i[0];
        end else if (gnt[1]) begin
            rom_addr_o = req_addr_i[1];
        end
    end

    always_comb begin
        rsp_valid_o          = 2'b00;
        rsp_valid_o[owner_q] = pend_q;
    end

    always_comb begin
        pend_d  = pend_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (|gnt) begin
            pend_d  = 1'b1;
            owner_d = gnt[1];
            last_d  = gnt[1];
        end else if (rsp_fire) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_rom_arb2.sv
// tb/tb_rom_arb2.sv - directed self-checking bench for rom_arb2 with a behavioural boot ROM.
module tb_rom_arb2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid_i;
    logic [1:0][7:0]  req_addr_i;
    logic [1:0]       req_ready_o;
    logic [1:0]       rsp_valid_o;
    logic [31:0]      rsp_data_o;
    logic [1:0]       rsp_ready_i;
    logic             rom_ce_o;
    logic [7:0]       rom_addr_o;
    logic [31:0]      rom_dout = 32'h0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rom_arb2 #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_ready_i (rsp_ready_i),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_dout_i  (rom_dout)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        if (a == 8'h05) return 32'h1234_5678;
        return {a, ~a, 8'h5A, a ^ 8'h3C};
    endfunction

    always @(posedge clk) begin
        if (rom_ce_o) rom_dout <= rom_word(rom_addr_o);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid_i = 2'b11;
        req_addr_i[0] = 8'h01;
        req_addr_i[1] = 8'h02;
        rsp_ready_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++; if (req_ready_o !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready_o); else passed++;
            checks++; if (rsp_valid_o !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid_o); else passed++;
            checks++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 8'h00) $display("FAIL reset_rom got ce=%b addr=%h exp ce=0 addr=00", rom_ce_o, rom_addr_o); else passed++;
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b01) $display("FAIL reset_first_grant got=%b exp=01", req_ready_o); else passed++;
        idle(2);
    endtask

    task automatic test_single();
        req_valid_i = 2'b01;
        req_addr_i[0] = 8'h05;
        #1;
        checks++; if (req_ready_o !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready_o); else passed++;
        checks++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 8'h05) $display("FAIL single_rom got ce=%b addr=%h exp ce=1 addr=05", rom_ce_o, rom_addr_o); else passed++;
        step();
        req_valid_i = 2'b00;
        #1;
        checks++; if (rsp_valid_o !== 2'b01) $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid_o); else passed++;
        checks++; if (rsp_data_o !== 32'h1234_5678) $display("FAIL single_rsp_data got=%h exp=12345678", rsp_data_o); else passed++;
        step();
        #1;
        checks++; if (rsp_valid_o !== 2'b00) $display("FAIL single_drain got=%b exp=00", rsp_valid_o); else passed++;
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            req_valid_i = 2'b10;
            req_addr_i[1] = 8'(k);
            #1;
            checks++; if (req_ready_o !== 2'b10) $display("FAIL b2b_ready[%0d] got=%b exp=10", k, req_ready_o); else passed++;
            if (k > 0) begin
                checks++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== rom_word(8'(k - 1)))
                    $display("FAIL b2b_rsp[%0d] got v=%b d=%h exp v=10 d=%h", k - 1, rsp_valid_o, rsp_data_o, rom_word(8'(k - 1)));
                else passed++;
            end
            step();
        end
        req_valid_i = 2'b00;
        #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== rom_word(8'd3))
            $display("FAIL b2b_rsp[3] got v=%b d=%h exp v=10 d=%h", rsp_valid_o, rsp_data_o, rom_word(8'd3));
        else passed++;
        idle(2);
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt [6];
        logic [1:0] prev;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        req_valid_i = 2'b11;
        req_addr_i[0] = 8'h10;
        req_addr_i[1] = 8'h20;
        prev = 2'b00;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready_o !== exp_gnt[k]) $display("FAIL contention_gnt[%0d] got=%b exp=%b", k, req_ready_o, exp_gnt[k]); else passed++;
            if (k > 0) begin
                checks++; if (rsp_valid_o !== prev || rsp_data_o !== rom_word(prev[1] ? 8'h20 : 8'h10))
                    $display("FAIL contention_rsp[%0d] got v=%b d=%h exp v=%b d=%h", k, rsp_valid_o, rsp_data_o, prev, rom_word(prev[1] ? 8'h20 : 8'h10));
                else passed++;
            end
            prev = exp_gnt[k];
            step();
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        req_valid_i = 2'b01;
        req_addr_i[0] = 8'h07;
        #1;
        checks++; if (req_ready_o !== 2'b01) $display("FAIL bp_grant0 got=%b exp=01", req_ready_o); else passed++;
        step();
        rsp_ready_i = 2'b10;
        req_valid_i = 2'b10;
        req_addr_i[1] = 8'h09;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== rom_word(8'h07))
                $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=01 d=%h", i, rsp_valid_o, rsp_data_o, rom_word(8'h07));
            else passed++;
            checks++; if (req_ready_o !== 2'b00 || rom_ce_o !== 1'b0)
                $display("FAIL bp_block[%0d] got ready=%b ce=%b exp ready=00 ce=0", i, req_ready_o, rom_ce_o);
            else passed++;
            step();
        end
        rsp_ready_i = 2'b11;
        #1;
        checks++; if (req_ready_o !== 2'b10 || rom_ce_o !== 1'b1 || rom_addr_o !== 8'h09)
            $display("FAIL bp_resume got ready=%b ce=%b addr=%h exp ready=10 ce=1 addr=09", req_ready_o, rom_ce_o, rom_addr_o);
        else passed++;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== rom_word(8'h07))
            $display("FAIL bp_release got v=%b d=%h exp v=01 d=%h", rsp_valid_o, rsp_data_o, rom_word(8'h07));
        else passed++;
        step();
        req_valid_i = 2'b00;
        #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== rom_word(8'h09))
            $display("FAIL bp_port1_rsp got v=%b d=%h exp v=10 d=%h", rsp_valid_o, rsp_data_o, rom_word(8'h09));
        else passed++;
        idle(2);
    endtask

    task automatic test_reset_mid_stall();
        req_valid_i = 2'b10;
        req_addr_i[1] = 8'h03;
        step();
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b01;
        #1;
        checks++; if (rsp_valid_o !== 2'b10) $display("FAIL rms_stalled got=%b exp=10", rsp_valid_o); else passed++;
        step();
        rst_n = 1'b0;
        step();
        #1;
        checks++; if (rsp_valid_o !== 2'b00) $display("FAIL rms_dropped got=%b exp=00", rsp_valid_o); else passed++;
        rst_n = 1'b1;
        rsp_ready_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            checks++; if (rsp_valid_o !== 2'b00 || req_ready_o !== 2'b00)
                $display("FAIL rms_no_stale[%0d] got v=%b ready=%b exp v=00 ready=00", i, rsp_valid_o, req_ready_o);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_backpressure();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
